cam_read: RTL and testbench

Camera-side writer for the frame buffer. Samples the OV7670 parallel bus (VSYNC, HREF, D[7:0]) on the camera pixel clock and packs each RGB565 byte pair into one RGB332 byte. Writes the bytes into the write port of `buffer_ram_dp` at linear address `row*CAM_SCREEN_X + col`. After each frame it writes the background colour to address `CAM_SCREEN_X*CAM_SCREEN_Y`, the address the VGA read side uses for every off-image pixel.

---
 rtl/cam_pkg.sv | 12 +
 rtl/cam_read.sv | 105 ++++++++++
 tb/tb_cam_read.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// cam_pkg: shared camera/VGA frame-buffer constants, RGB332 colours and capture FSM encoding
package cam_pkg;
  localparam int CAM_SCREEN_X = 160;
  localparam int CAM_SCREEN_Y = 120;
  localparam int AW = 15;
  localparam int DW = 8;
  localparam logic [7:0] RED_VGA = 8'hE0;
  localparam logic [7:0] GREEN_VGA = 8'h1C;
  localparam logic [7:0] BLUE_VGA = 8'h03;
  localparam logic [7:0] BLACK_VGA = 8'h00;
  typedef enum logic [2:0] {WAIT_VS_HIGH, WAIT_VS_LOW, BYTE1, BYTE2, BG_WRITE} cam_state_t;
endpackage

// File: rtl/cam_read.sv
// cam_read: OV7670 RGB565 byte stream -> RGB332 frame-buffer writes (in: clk, rst_n-style rst, vsync, href, px_data; out: mem_px_addr, mem_px_data, px_wr, frame_done)
module cam_read import cam_pkg::*; #(
  parameter int CAM_SCREEN_X = cam_pkg::CAM_SCREEN_X,
  parameter int CAM_SCREEN_Y = cam_pkg::CAM_SCREEN_Y,
  parameter int AW = cam_pkg::AW,
  parameter int DW = cam_pkg::DW,
  parameter logic [DW-1:0] BG_COLOR = cam_pkg::BLACK_VGA
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr,
  output logic          frame_done
);
  localparam int CW = $clog2(CAM_SCREEN_X + 1);
  localparam int RW = $clog2(CAM_SCREEN_Y + 1);
  localparam logic [AW-1:0] BG_ADDR = AW'(CAM_SCREEN_X * CAM_SCREEN_Y);
  localparam logic [AW-1:0] X_STEP = AW'(CAM_SCREEN_X);
  localparam logic [CW-1:0] X_MAX = CW'(CAM_SCREEN_X);
  localparam logic [RW-1:0] Y_MAX = RW'(CAM_SCREEN_Y);
  localparam logic [RW-1:0] Y_LAST = RW'(CAM_SCREEN_Y - 1);
  cam_state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [AW-1:0] base_q, base_d, addr_d;
  logic [5:0] hi_q, hi_d;
  logic line_q, line_d, wr_d, done_d, keep;
  logic [DW-1:0] data_d;
  always_comb begin
    keep = col_q < X_MAX && row_q < Y_MAX;
    state_d = state_q;
    col_d = col_q;
    row_d = row_q;
    base_d = base_q;
    hi_d = hi_q;
    line_d = line_q;
    wr_d = 1'b0;
    done_d = 1'b0;
    addr_d = '0;
    data_d = '0;
    case (state_q)
      WAIT_VS_HIGH: state_d = vsync ? WAIT_VS_LOW : WAIT_VS_HIGH;
      WAIT_VS_LOW: if (!vsync) begin
        state_d = BYTE1;
        col_d = '0;
        row_d = '0;
        base_d = '0;
        line_d = 1'b0;
      end
      BG_WRITE: begin
        state_d = WAIT_VS_LOW;
        wr_d = 1'b1;
        done_d = 1'b1;
        addr_d = BG_ADDR;
        data_d = BG_COLOR;
      end
      default:
        if (vsync) state_d = BG_WRITE;
        else if (line_q && !href) begin
          // base stops one row early so it never exceeds (Y-1)*X
          state_d = BYTE1;
          line_d = 1'b0;
          col_d = '0;
          row_d = row_q < Y_MAX ? row_q + RW'(1) : row_q;
          base_d = row_q < Y_LAST ? base_q + X_STEP : base_q;
        end else if (href) begin
          line_d = 1'b1;
          state_d = state_q == BYTE1 ? BYTE2 : BYTE1;
          hi_d = state_q == BYTE1 ? {px_data[7:5], px_data[2:0]} : hi_q;
          wr_d = state_q == BYTE2 && keep;
          addr_d = wr_d ? base_q + AW'(col_q) : '0;
          data_d = wr_d ? DW'({hi_q, px_data[4:3]}) : '0;
          col_d = wr_d ? col_q + CW'(1) : col_q;
        end
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= WAIT_VS_HIGH;
      col_q <= '0;
      row_q <= '0;
      base_q <= '0;
      hi_q <= '0;
      line_q <= 1'b0;
      px_wr <= 1'b0;
      frame_done <= 1'b0;
      mem_px_addr <= '0;
      mem_px_data <= '0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      base_q <= base_d;
      hi_q <= hi_d;
      line_q <= line_d;
      px_wr <= wr_d;
      frame_done <= done_d;
      mem_px_addr <= addr_d;
      mem_px_data <= data_d;
    end
endmodule

// File: tb/tb_cam_read.sv
// tb_cam_read: randomized self-checking bench for cam_read against a write-list reference model
module tb_cam_read;
  localparam int X = 160;
  localparam int Y = 120;
  localparam int AW = 15;
  localparam int DW = 8;
  localparam logic [7:0] BG = 8'h00;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic vsync = 1'b0;
  logic href = 1'b0;
  logic [7:0] px_data = 8'h00;
  logic [AW-1:0] mem_px_addr;
  logic [DW-1:0] mem_px_data;
  logic px_wr, frame_done;
  int n_chk = 0;
  int n_fail = 0;
  int n_wr = 0;
  int m_row = 0;
  int max_addr = 0;
  int w0;
  logic [31:0] exp_q[$];
  logic [7:0] lb[$];
  cam_read dut (
    .clk(clk),
    .rst(rst),
    .vsync(vsync),
    .href(href),
    .px_data(px_data),
    .mem_px_addr(mem_px_addr),
    .mem_px_data(mem_px_data),
    .px_wr(px_wr),
    .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] rgb332(logic [7:0] b1, logic [7:0] b2);
    int v = (int'(b1) / 32) * 32 + (int'(b1) % 8) * 4 + (int'(b2) / 8) % 4;
    return 8'(v);
  endfunction
  function automatic logic [31:0] ent(logic done, int addr, logic [7:0] d);
    logic [14:0] a = 15'(addr);
    return {7'd0, done, 1'b1, a, d};
  endfunction
  task automatic cyc(logic v, logic h, logic [7:0] d);
    @(negedge clk);
    vsync = v;
    href = h;
    px_data = d;
  endtask
  task automatic frame_start();
    repeat (3) cyc(1'b1, 1'b0, 8'h00);
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    m_row = 0;
  endtask
  task automatic frame_end();
    exp_q.push_back(ent(1'b1, X * Y, BG));
    repeat (4) cyc(1'b1, 1'b0, 8'h00);
  endtask
  task automatic rand_line(int n);
    lb.delete();
    repeat (n) lb.push_back(8'($urandom));
  endtask
  task automatic model_line(int n);
    if (n == 0) return;
    for (int i = 0; i < n / 2; i++)
      if (i < X && m_row < Y) exp_q.push_back(ent(1'b0, m_row * X + i, rgb332(lb[2*i], lb[2*i+1])));
    m_row++;
  endtask
  task automatic drive(int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, lb[i]);
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
  endtask
  task automatic line(int n);
    rand_line(n);
    model_line(n);
    drive(n);
  endtask
  task automatic drain(string tag);
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask
  always @(negedge clk)
    if (rst && (px_wr || frame_done)) begin
      if (px_wr) n_wr++;
      if (int'(mem_px_addr) > max_addr) max_addr = int'(mem_px_addr);
      if (exp_q.size() == 0) chk("spurious_wr", {frame_done, px_wr, mem_px_addr, mem_px_data}, 32'd0);
      else chk("wr", {7'd0, frame_done, px_wr, mem_px_addr, mem_px_data}, exp_q.pop_front());
    end
  initial begin
    #1_500_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_out", {frame_done, px_wr, mem_px_addr, mem_px_data}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    // bytes before any vsync edge must never be captured
    lb.delete();
    repeat (20) lb.push_back(8'hF8);
    drive(20);
    chk("pre_vsync_quiet", n_wr, 0);
    // full red frame
    frame_start();
    lb.delete();
    for (int i = 0; i < 2 * X; i++) lb.push_back(i % 2 ? 8'h00 : 8'hF8);
    for (int r = 0; r < Y; r++) begin
      for (int c = 0; c < X; c++) exp_q.push_back(ent(1'b0, r * X + c, 8'hE0));
      drive(2 * X);
    end
    frame_end();
    drain("full_frame_drain");
    chk("full_frame_count", n_wr, X * Y + 1);
    // packing vectors on an odd-length line, then random lines
    frame_start();
    lb = {8'h07, 8'hE0, 8'h00, 8'h1F, 8'hAD, 8'h55, 8'($urandom)};
    exp_q.push_back(ent(1'b0, 0, 8'h1C));
    exp_q.push_back(ent(1'b0, 1, 8'h03));
    exp_q.push_back(ent(1'b0, 2, 8'hB6));
    m_row = 1;
    drive(7);
    rand_line(10);
    exp_q.push_back(ent(1'b0, 160, rgb332(lb[0], lb[1])));
    for (int i = 1; i < 5; i++) exp_q.push_back(ent(1'b0, 160 + i, rgb332(lb[2*i], lb[2*i+1])));
    m_row = 2;
    drive(10);
    repeat (15) line($urandom_range(1, 400));
    frame_end();
    drain("pack_random_drain");
    // long and extra lines
    max_addr = 0;
    frame_start();
    for (int r = 0; r < 130; r++) line((r < 5 || r >= 125) ? 400 : $urandom_range(2, 12));
    frame_end();
    drain("long_extra_drain");
    chk("max_addr_le_bg", max_addr <= X * Y, 1);
    // early vsync mid-pixel on line 50
    frame_start();
    repeat (50) line($urandom_range(1, 30));
    rand_line(11);
    model_line(5);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, lb[i]);
    cyc(1'b1, 1'b1, lb[5]);
    frame_end();
    drain("early_vsync_drain");
    // asynchronous reset in the middle of line 10
    frame_start();
    repeat (10) line(20);
    rand_line(20);
    model_line(6);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, lb[i]);
    @(negedge clk);
    chk("wr_before_rst", px_wr, 1);
    #1 rst = 1'b0;
    #1 chk("rst_async_clear", {frame_done, px_wr, mem_px_addr, mem_px_data}, 32'd0);
    repeat (3) cyc(1'b0, 1'b1, 8'($urandom));
    @(negedge clk);
    rst = 1'b1;
    w0 = n_wr;
    repeat (4) begin
      rand_line(20);
      drive(20);
    end
    chk("no_wr_after_rst", n_wr, w0);
    drain("rst_drain");
    frame_start();
    rand_line(8);
    exp_q.push_back(ent(1'b0, 0, rgb332(lb[0], lb[1])));
    for (int i = 1; i < 4; i++) exp_q.push_back(ent(1'b0, i, rgb332(lb[2*i], lb[2*i+1])));
    m_row = 1;
    drive(8);
    repeat (3) line($urandom_range(1, 60));
    frame_end();
    drain("post_rst_frame_drain");
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
